// File: rtl/core_host_if.sv
`default_nettype none
// ============================================================================
// Module      : core_host_if
// Description : Program-beat stream plus register-interface words between the
//               host driver and the compute core.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_host_if;
    logic        prog_valid;
    logic [43:0] prog_data;
    logic        prog_last;
    logic        prog_ready;
    logic [31:0] control_low_word;
    logic [31:0] control_high_word;
    logic [31:0] dina_ext_low_word;
    logic [31:0] dina_ext_high_word;
    logic [31:0] status;

    modport master (
        input  prog_valid, prog_data, prog_last, status,
        output prog_ready, control_low_word, control_high_word,
               dina_ext_low_word, dina_ext_high_word
    );

    modport slave (
        output prog_valid, prog_data, prog_last, status,
        input  prog_ready, control_low_word, control_high_word,
               dina_ext_low_word, dina_ext_high_word
    );
endinterface
`default_nettype wire

// File: rtl/core_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : core_host_driver
// Description : Resets the core, loads up to 16 instruction words, starts the
//               run and waits for done_all or a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module core_host_driver #(
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1048576
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        run_req,
    input  wire logic [1:0]  n_expand,
    core_host_if.master      bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [29:0]      cycles
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RSTC  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_START = 3'd4;
    localparam logic [2:0] S_LAT   = 3'd5;
    localparam logic [2:0] S_WAIT  = 3'd6;
    localparam logic [2:0] S_FIN   = 3'd7;

    localparam logic [23:0] c_rst_last = 24'(RST_CYCLES - 1);
    localparam logic [23:0] c_tmo_last = 24'(TIMEOUT - 1);
    localparam logic [23:0] c_lat_last = 24'd1;

    logic [2:0]  r_state, w_state_nxt;
    logic [23:0] r_cnt;
    logic [3:0]  r_addr;
    logic [43:0] r_data;
    logic        r_last;
    logic [1:0]  r_nexp;
    logic        r_ready, r_wea, r_isa, r_core_rst, r_start;
    logic        r_busy, r_done, r_error;
    logic [29:0] r_cycles;
    logic        w_accept, w_err_set, w_count;
    logic        w_unused_status;

    assign w_unused_status = bus.status[1];

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE:  if (run_req) w_state_nxt = S_RSTC;
            S_RSTC:  if (r_cnt == c_rst_last) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (bus.prog_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_last) begin
                    w_state_nxt = S_START;
                end else if (r_addr == 4'hF) begin
                    // program does not fit: written, but never started
                    w_state_nxt = S_FIN;
                    w_err_set   = 1'b1;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_START: w_state_nxt = S_LAT;
            S_LAT:   if (r_cnt == c_lat_last) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.status[0]) begin
                    w_state_nxt = S_FIN;
                end else if (r_cnt == c_tmo_last) begin
                    w_state_nxt = S_FIN;
                    w_err_set   = 1'b1;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // one counter serves reset hold, status latency and timeout
    assign w_count = (w_state_nxt == r_state) &&
                     (r_state == S_RSTC || r_state == S_LAT || r_state == S_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_nexp     <= '0;
            r_ready    <= 1'b0;
            r_wea      <= 1'b0;
            r_isa      <= 1'b0;
            r_core_rst <= 1'b0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cycles   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_count ? r_cnt + 24'd1 : '0;
            if (r_state == S_IDLE && run_req) begin
                r_error <= 1'b0;
                r_nexp  <= n_expand;
                r_addr  <= '0;
            end
            if (w_accept) begin
                r_data <= bus.prog_data;
                r_last <= bus.prog_last;
            end
            if (r_state == S_WRITE && w_state_nxt == S_LOAD) r_addr <= r_addr + 4'd1;
            if (w_err_set) r_error <= 1'b1;
            if (r_state == S_WAIT && bus.status[0]) r_cycles <= bus.status[31:2];
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_FIN);
            r_ready    <= (w_state_nxt == S_LOAD);
            r_wea      <= (w_state_nxt == S_WRITE);
            r_isa      <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_WRITE);
            r_core_rst <= (w_state_nxt == S_RSTC);
            r_start    <= (w_state_nxt == S_START);
        end
    end

    assign bus.prog_ready         = r_ready;
    assign bus.control_low_word   = {3'b000, r_nexp, 8'h00, 1'b0, r_isa, r_wea, 12'h000, r_addr};
    assign bus.control_high_word  = {30'd0, r_start, r_core_rst};
    assign bus.dina_ext_low_word  = r_data[31:0];
    assign bus.dina_ext_high_word = {20'd0, r_data[43:32]};

    assign busy   = r_busy;
    assign done   = r_done;
    assign error  = r_error;
    assign cycles = r_cycles;
endmodule
`default_nettype wire

// File: doc/core_host_driver.md
CORE_HOST_DRIVER -- requirements
Module: core_host_driver

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4: cycles the core/ISA reset bit is held per run.
REQ-002 SHALL have parameter TIMEOUT, default 1048576: maximum WAIT_DONE cycles before abort.
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port run_req, input, 1: one-cycle request to start a program run; honoured only in IDLE.
REQ-006 SHALL have port n_expand, input, 2: sampled on an accepted run_req.
REQ-007 SHALL have port prog_valid, input, 1: instruction beat valid.
REQ-008 SHALL have port prog_data, input, 44: instruction word.
REQ-009 SHALL have port prog_last, input, 1: marks the final beat.
REQ-010 SHALL have port prog_ready, output, 1: beat accepted when prog_valid and prog_ready are both 1.
REQ-011 SHALL have ports control_low_word, control_high_word, dina_ext_low_word, dina_ext_high_word, outputs, 32 each: register-interface words toward the compute core, all registered.
REQ-012 SHALL have port status, input, 32: bit0 = done_all, bits31:2 = cycle count[29:0]; arrives one cycle registered.
REQ-013 SHALL have ports busy (1), done (1-cycle pulse), error (1), cycles (30), all outputs.

Function
REQ-014 control_low_word SHALL be: [15:0] address, [16] wea, [17] ISA select = 1 during loads, [18] grant = 0, [28:27] captured n_expand, [31:29] bram_sel = 0.
REQ-015 control_high_word SHALL be: [0] core/ISA reset, [1] start, [31:2] = 0.
REQ-016 dina_ext_high_word SHALL be {20'b0, data[43:32]} and dina_ext_low_word SHALL be data[31:0].
REQ-017 The FSM SHALL have the states IDLE, RSTC, LOAD, WRITE, START, LAT, WAIT, FIN.
REQ-018 IDLE: busy = 0 and prog_ready = 0; on run_req the FSM SHALL clear error, capture n_expand, zero the address counter, and go to RSTC.
REQ-019 RSTC: the FSM SHALL drive control_high_word[0] = 1 for exactly RST_CYCLES cycles, then go to LOAD with bit0 = 0.
REQ-020 LOAD: prog_ready = 1; on an accepted beat the FSM SHALL register address/data and go to WRITE.
REQ-021 WRITE: for exactly one cycle, the FSM SHALL drive wea = 1, bit17 = 1, address = counter (0..15) and dina = beat, with prog_ready = 0; the next cycle wea SHALL be 0.
REQ-022 After WRITE, the FSM SHALL go to START if the beat had prog_last, else increment the counter and go to LOAD. Maximum throughput is one beat per 2 cycles.
REQ-023 If the beat at address 15 lacks prog_last, it SHALL still be written, and the FSM SHALL then go to FIN with error = 1 (overflow; no start issued).
REQ-024 START: the FSM SHALL drive control_high_word[1] = 1 for one cycle, then go to LAT.
REQ-025 LAT: the FSM SHALL ignore status for 2 cycles (stale done_all from the register stage), then go to WAIT.
REQ-026 WAIT: when status[0] = 1, the FSM SHALL latch cycles <= status[31:2] and go to FIN; the timeout counter (24-bit) SHALL increment each WAIT cycle, and on reaching TIMEOUT the FSM SHALL go to FIN with error = 1 and cycles unchanged.
REQ-027 FIN: the FSM SHALL pulse done for 1 cycle, then go to IDLE; error SHALL persist until the next accepted run_req.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 run_req outside IDLE SHALL be ignored; run_req coincident with FIN SHALL be ignored.
REQ-030 prog_valid outside LOAD SHALL be ignored (not consumed).

Reset
REQ-031 On rst = 1, all outputs SHALL become 0 on the next edge, the FSM SHALL go to IDLE, and all counters SHALL clear, including mid-load or mid-wait; no partial wea pulse SHALL follow.

Verification
REQ-032 Run with 3 beats (last on the 3rd) -> high[0] = 1 for 4 cycles; wea pulses at addresses 0, 1, 2 with bit17 = 1; one start pulse; status 0x00000029 after LAT -> cycles = 10, done pulse, error = 0.
REQ-033 Beat data 0xABC_12345678 -> dina_high = 0x00000ABC and dina_low = 0x12345678 during the WRITE cycle.
REQ-034 16 beats without last -> 16 writes, no start, done pulse with error = 1.
REQ-035 status[0] held at 1 across start -> ignored for 2 LAT cycles; status[0] never rises in WAIT with TIMEOUT = 8 -> error = 1 after 8 WAIT cycles.
REQ-036 rst asserted in WRITE -> next cycle all outputs 0 and state IDLE; a subsequent run completes normally.
REQ-037 run_req with n_expand = 2 -> control_low_word[28:27] = 2 for the whole run; a run_req during WAIT has no effect.
